// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the frame-granular AXI-Stream arbiter.
// Holds the arbiter state encoding and the byte-count rule for tkeep.
package axis_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

    localparam int              LEN_W      = 16;
    localparam logic [LEN_W-1:0] LEN_MAX   = 16'hFFFF;
    localparam int              MAX_KEEP_W = 64;

    // Only LSB-contiguous keep patterns carry bytes; sparse patterns count as zero.
    function automatic logic [LEN_W-1:0] keep_to_bytes(input logic [MAX_KEEP_W-1:0] keep,
                                                        input int keepW);
        logic [LEN_W-1:0]      n;
        logic [MAX_KEEP_W-1:0] mask;
        n    = '0;
        mask = '0;
        for (int i = 1; i <= MAX_KEEP_W; i++) begin
            mask = {mask[MAX_KEEP_W-2:0], 1'b1};
            if ((i <= keepW) && (keep == mask)) begin
                n = LEN_W'(i);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning from ptr upward,
// wrapping modulo N_PORTS.
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int SRC_W   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    int w_idx;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N_PORTS; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N_PORTS) begin
                w_idx = w_idx - N_PORTS;
            end
            if (!gnt_any && req[w_idx[SRC_W-1:0]]) begin
                gnt_idx = w_idx[SRC_W-1:0];
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_frame_arb.sv
// Frame-granular round-robin AXI-Stream arbiter that also reports the byte length
// and source port of every forwarded frame.
module axis_frame_arb
    import axis_arb_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int KEEP_W  = 8,
    parameter int SRC_W   = $clog2(N_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS*8*KEEP_W-1:0]   s_axis_tdata,
    input  logic [N_PORTS*KEEP_W-1:0]     s_axis_tkeep,
    input  logic [N_PORTS-1:0]            s_axis_tvalid,
    input  logic [N_PORTS-1:0]            s_axis_tlast,
    output logic [N_PORTS-1:0]            s_axis_tready,
    output logic [8*KEEP_W-1:0]           m_axis_tdata,
    output logic [KEEP_W-1:0]             m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [LEN_W-1:0]              frame_len,
    output logic                          frame_len_valid,
    output logic [SRC_W-1:0]              frame_src
);

    localparam int DATA_W = 8 * KEEP_W;

    arb_state_t         r_state;
    arb_state_t         w_stateNext;
    logic [SRC_W-1:0]   r_grant;
    logic [SRC_W-1:0]   w_grantNext;
    logic [SRC_W-1:0]   r_rrPtr;
    logic [SRC_W-1:0]   w_rrPtrNext;
    logic [LEN_W-1:0]   r_acc;
    logic [LEN_W-1:0]   w_accNext;
    logic [LEN_W-1:0]   r_frameLen;
    logic [LEN_W-1:0]   w_frameLenNext;
    logic [SRC_W-1:0]   r_frameSrc;
    logic [SRC_W-1:0]   w_frameSrcNext;
    logic               r_lenValid;
    logic               w_lenValidNext;

    logic [SRC_W-1:0]   w_pickIdx;
    logic               w_pickAny;
    logic [DATA_W-1:0]  w_selData;
    logic [KEEP_W-1:0]  w_selKeep;
    logic               w_selValid;
    logic               w_selLast;
    logic               w_beat;
    logic [LEN_W-1:0]   w_beatBytes;
    logic [LEN_W:0]     w_sum;
    logic [LEN_W-1:0]   w_accSat;
    logic [SRC_W-1:0]   w_grantInc;

    axis_rr_pick #(
        .N_PORTS (N_PORTS),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req     (s_axis_tvalid),
        .ptr     (r_rrPtr),
        .gnt_idx (w_pickIdx),
        .gnt_any (w_pickAny)
    );

    assign w_selData   = s_axis_tdata[int'(r_grant)*DATA_W +: DATA_W];
    assign w_selKeep   = s_axis_tkeep[int'(r_grant)*KEEP_W +: KEEP_W];
    assign w_selValid  = s_axis_tvalid[r_grant];
    assign w_selLast   = s_axis_tlast[r_grant];

    // Byte accumulation saturates so very long frames report LEN_MAX instead of wrapping.
    assign w_beatBytes = keep_to_bytes(MAX_KEEP_W'(w_selKeep), KEEP_W);
    assign w_sum       = {1'b0, r_acc} + {1'b0, w_beatBytes};
    assign w_accSat    = w_sum[LEN_W] ? LEN_MAX : w_sum[LEN_W-1:0];
    assign w_grantInc  = (r_grant == SRC_W'(N_PORTS - 1)) ? '0 : r_grant + 1'b1;

    // Next-state and datapath control: IDLE arbitrates for one cycle, ACTIVE passes
    // the granted port straight through until its tlast beat is accepted.
    always_comb begin
        w_stateNext    = r_state;
        w_grantNext    = r_grant;
        w_rrPtrNext    = r_rrPtr;
        w_accNext      = r_acc;
        w_frameLenNext = r_frameLen;
        w_frameSrcNext = r_frameSrc;
        w_lenValidNext = 1'b0;
        w_beat         = 1'b0;
        s_axis_tready  = '0;
        m_axis_tdata   = '0;
        m_axis_tkeep   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pickAny) begin
                    w_grantNext = w_pickIdx;
                    w_accNext   = '0;
                    w_stateNext = ACTIVE;
                end
            end
            ACTIVE: begin
                m_axis_tdata           = w_selData;
                m_axis_tkeep           = w_selKeep;
                m_axis_tvalid          = w_selValid;
                m_axis_tlast           = w_selLast;
                s_axis_tready[r_grant] = m_axis_tready;
                w_beat                 = w_selValid & m_axis_tready;
                if (w_beat) begin
                    w_accNext = w_accSat;
                    if (w_selLast) begin
                        w_frameLenNext = w_accSat;
                        w_frameSrcNext = r_grant;
                        w_lenValidNext = 1'b1;
                        w_rrPtrNext    = w_grantInc;
                        w_stateNext    = IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Reset abandons any frame in flight without reporting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rrPtr    <= '0;
            r_acc      <= '0;
            r_frameLen <= '0;
            r_frameSrc <= '0;
            r_lenValid <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_grant    <= w_grantNext;
            r_rrPtr    <= w_rrPtrNext;
            r_acc      <= w_accNext;
            r_frameLen <= w_frameLenNext;
            r_frameSrc <= w_frameSrcNext;
            r_lenValid <= w_lenValidNext;
        end
    end

    assign frame_len       = r_frameLen;
    assign frame_src       = r_frameSrc;
    assign frame_len_valid = r_lenValid;

endmodule

// File: tb/tb_axis_frame_arb.sv
// Scoreboard bench for axis_frame_arb: directed frames push expected beats and
// length reports; an independent monitor pops and compares them.
module tb_axis_frame_arb;

    localparam int N_PORTS    = 4;
    localparam int KEEP_W     = 8;
    localparam int DATA_W     = 64;
    localparam int WAIT_LIMIT = 20000;

    typedef struct {
        logic [1:0]  port;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        logic [15:0] len;
        logic [1:0]  src;
    } rep_t;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [N_PORTS*DATA_W-1:0]   sData;
    logic [N_PORTS*KEEP_W-1:0]   sKeep;
    logic [N_PORTS-1:0]          txValid = '0;
    logic [N_PORTS-1:0]          txLast = '0;
    logic [N_PORTS-1:0]          sReady;
    logic [DATA_W-1:0]           mData;
    logic [KEEP_W-1:0]           mKeep;
    logic                        mValid;
    logic                        mLast;
    logic                        mReady = 1'b1;
    logic [15:0]                 frameLen;
    logic                        lenValid;
    logic [1:0]                  frameSrc;

    logic [DATA_W-1:0]           txData [N_PORTS];
    logic [KEEP_W-1:0]           txKeep [N_PORTS];
    logic                        readyMode = 1'b0;

    beat_t expBeats[$];
    rep_t  expReps[$];
    int    checks   = 0;
    int    failures = 0;

    axis_frame_arb #(
        .N_PORTS (N_PORTS),
        .KEEP_W  (KEEP_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tdata    (sData),
        .s_axis_tkeep    (sKeep),
        .s_axis_tvalid   (txValid),
        .s_axis_tlast    (txLast),
        .s_axis_tready   (sReady),
        .m_axis_tdata    (mData),
        .m_axis_tkeep    (mKeep),
        .m_axis_tvalid   (mValid),
        .m_axis_tlast    (mLast),
        .m_axis_tready   (mReady),
        .frame_len       (frameLen),
        .frame_len_valid (lenValid),
        .frame_src       (frameSrc)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            sData[i*DATA_W +: DATA_W] = txData[i];
            sKeep[i*KEEP_W +: KEEP_W] = txKeep[i];
        end
    end

    // Downstream ready either stays high or toggles every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (readyMode) mReady = ~mReady;
            else           mReady = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] beatData(input logic [1:0] port, input int frameId, input int beat);
        return {8'(port), 8'(frameId), 16'(beat), 32'hC0DE0000 + 32'(beat)};
    endfunction

    function automatic logic [7:0] keepFor(input int beat, input int nBeats,
                                           input logic [7:0] body, input logic [7:0] last);
        return (beat == nBeats - 1) ? last : body;
    endfunction

    task automatic pushBeat(input logic [1:0] port, input int frameId, input int beat,
                            input logic [7:0] keep, input logic last);
        beat_t b;
        b.port = port;
        b.data = beatData(port, frameId, beat);
        b.keep = keep;
        b.last = last;
        expBeats.push_back(b);
    endtask

    task automatic expectFrame(input logic [1:0] port, input int frameId, input int nBeats,
                               input logic [7:0] body, input logic [7:0] last, input logic [15:0] len);
        rep_t r;
        for (int b = 0; b < nBeats; b++) begin
            pushBeat(port, frameId, b, keepFor(b, nBeats, body, last), b == nBeats - 1);
        end
        r.len = len;
        r.src = port;
        expReps.push_back(r);
    endtask

    task automatic driveBeat(input logic [1:0] port, input logic [63:0] data,
                             input logic [7:0] keep, input logic last);
        int waited;
        waited        = 0;
        txData[port]  = data;
        txKeep[port]  = keep;
        txLast[port]  = last;
        txValid[port] = 1'b1;
        @(negedge clk);
        while (!sReady[port]) begin
            waited++;
            if (waited > WAIT_LIMIT) begin
                checks++;
                failures++;
                $display("[TB] FAIL handshake_timeout port=%0d actual=no_ready expected=ready", port);
                txValid[port] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] port, input int frameId, input int nBeats,
                                 input logic [7:0] body, input logic [7:0] last, input int gapAt);
        for (int b = 0; b < nBeats; b++) begin
            if (b == gapAt) begin
                txValid[port] = 1'b0;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
            end
            driveBeat(port, beatData(port, frameId, b), keepFor(b, nBeats, body, last), b == nBeats - 1);
        end
        txValid[port] = 1'b0;
        txLast[port]  = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expBeats.size() != 0 || expReps.size() != 0) && n < WAIT_LIMIT) begin
            @(posedge clk);
            n++;
        end
        checkOutput("drain", 64'(expBeats.size() + expReps.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output beat and every length pulse is matched in order.
    initial begin
        beat_t e;
        rep_t  r;
        forever begin
            @(negedge clk);
            checkOutput("ready_onehot", 64'($countones(sReady) <= 1), 64'd1);
            if (!rst && mValid && mReady) begin
                if (expBeats.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_beat actual=0x%0h expected=none", mData);
                end else begin
                    e = expBeats.pop_front();
                    checkOutput("beat_data", mData, e.data);
                    checkOutput("beat_keep", 64'(mKeep), 64'(e.keep));
                    checkOutput("beat_last", 64'(mLast), 64'(e.last));
                    checkOutput("beat_ready_port", 64'(sReady), 64'(4'b0001 << e.port));
                end
            end
            if (lenValid) begin
                if (expReps.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_pulse actual=len%0d_src%0d expected=none", frameLen, frameSrc);
                end else begin
                    r = expReps.pop_front();
                    checkOutput("frame_len", 64'(frameLen), 64'(r.len));
                    checkOutput("frame_src", 64'(frameSrc), 64'(r.src));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N_PORTS; i++) begin
            txData[i] = '0;
            txKeep[i] = '0;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("rst_frame_len", 64'(frameLen), 64'd0);
        checkOutput("rst_frame_src", 64'(frameSrc), 64'd0);
        checkOutput("rst_len_valid", 64'(lenValid), 64'd0);
        checkOutput("rst_m_valid", 64'(mValid), 64'd0);
        checkOutput("rst_s_ready", 64'(sReady), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] three-beat frame from port 1");
        expectFrame(2'd1, 1, 3, 8'hFF, 8'h0F, 16'd20);
        fork
            applyStimulus(2'd1, 1, 3, 8'hFF, 8'h0F, -1);
            begin
                @(negedge clk);
                checkOutput("bubble_m_valid", 64'(mValid), 64'd0);
                checkOutput("bubble_s_ready", 64'(sReady), 64'd0);
                @(negedge clk);
                checkOutput("first_beat_valid", 64'(mValid), 64'd1);
            end
        join
        waitDrain();
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("len_hold", 64'(frameLen), 64'd20);
        checkOutput("src_hold", 64'(frameSrc), 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] single-beat frame from port 3");
        expectFrame(2'd3, 2, 1, 8'h01, 8'h01, 16'd1);
        applyStimulus(2'd3, 2, 1, 8'h01, 8'h01, -1);
        waitDrain();

        $display("[TB] ports 0 and 2 contend, expect order 0,2,0");
        expectFrame(2'd0, 3, 2, 8'hFF, 8'h03, 16'd10);
        expectFrame(2'd2, 4, 3, 8'h0F, 8'h0F, 16'd12);
        expectFrame(2'd0, 5, 1, 8'hFF, 8'hFF, 16'd8);
        fork
            begin
                applyStimulus(2'd0, 3, 2, 8'hFF, 8'h03, -1);
                applyStimulus(2'd0, 5, 1, 8'hFF, 8'hFF, -1);
            end
            applyStimulus(2'd2, 4, 3, 8'h0F, 8'h0F, -1);
        join
        waitDrain();

        $display("[TB] toggling downstream ready with a valid gap");
        readyMode = 1'b1;
        expectFrame(2'd1, 6, 4, 8'hFF, 8'h03, 16'd26);
        expectFrame(2'd3, 7, 2, 8'hFF, 8'h0F, 16'd12);
        fork
            applyStimulus(2'd1, 6, 4, 8'hFF, 8'h03, 2);
            applyStimulus(2'd3, 7, 2, 8'hFF, 8'h0F, -1);
        join
        waitDrain();
        readyMode = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        $display("[TB] saturating frame and sparse keep");
        expectFrame(2'd0, 8, 9000, 8'hFF, 8'hFF, 16'hFFFF);
        applyStimulus(2'd0, 8, 9000, 8'hFF, 8'hFF, -1);
        waitDrain();
        expectFrame(2'd0, 9, 2, 8'h05, 8'h03, 16'd2);
        applyStimulus(2'd0, 9, 2, 8'h05, 8'h03, -1);
        waitDrain();

        $display("[TB] reset during a port 2 frame");
        pushBeat(2'd2, 10, 0, 8'hFF, 1'b0);
        pushBeat(2'd2, 10, 1, 8'hFF, 1'b0);
        driveBeat(2'd2, beatData(2'd2, 10, 0), 8'hFF, 1'b0);
        driveBeat(2'd2, beatData(2'd2, 10, 1), 8'hFF, 1'b0);
        txValid[2] = 1'b0;
        rst        = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("rst_mid_len_valid", 64'(lenValid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_m_valid", 64'(mValid), 64'd0);
        checkOutput("post_rst_s_ready", 64'(sReady), 64'd0);
        checkOutput("post_rst_frame_len", 64'(frameLen), 64'd0);
        checkOutput("post_rst_frame_src", 64'(frameSrc), 64'd0);
        @(posedge clk);
        #1;
        expectFrame(2'd0, 11, 1, 8'h0F, 8'h0F, 16'd4);
        expectFrame(2'd2, 12, 3, 8'hFF, 8'h01, 16'd17);
        fork
            applyStimulus(2'd0, 11, 1, 8'h0F, 8'h0F, -1);
            applyStimulus(2'd2, 12, 3, 8'hFF, 8'h01, -1);
        join
        waitDrain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
